// File: rtl/dmc_channel.sv
// dmc_channel -- delta-modulation channel of the APU.
//
// Fetches 1-bit delta sample bytes over a DMA request/acknowledge handshake,
// shifts them out LSB first at the selected NTSC rate, and moves the 7-bit
// output level up or down by 2 for each bit. It also raises the DMC interrupt
// and reports whether sample bytes remain.
//
// Ports:
//   clk, rst_l               clock, asynchronous active-low reset
//   cpu_clk_en               one-cycle pulse per CPU cycle (timer/output advance)
//   irq_en, loop, rate_index $4010 fields
//   direct_load(_data)       $4011 write strobe and value
//   sample_addr_in           $4012 (start = $C000 + value*64)
//   sample_len_in            $4013 (length = value*16 + 1 bytes)
//   status_write, enable     $4015 write strobe and bit 4
//   dma_req, dma_addr        fetch request and address
//   dma_ack, dma_data        fetch acknowledge pulse and returned byte
//   bytes_remaining_non_zero status bit 4 for $4015 reads
//   irq                      DMC interrupt flag
//   out                      7-bit level to the mixer
//
// Handshake: dma_req is decoded straight from registered state (buffer empty
// and bytes remaining), so it rises the cycle after that condition forms and
// holds dma_addr stable. A dma_ack pulse is a transfer only while dma_req is
// high; dma_req then falls the next cycle because the buffer is full.
module dmc_channel (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        cpu_clk_en,
  input  logic        irq_en,
  input  logic        loop,
  input  logic [3:0]  rate_index,
  input  logic        direct_load,
  input  logic [6:0]  direct_load_data,
  input  logic [7:0]  sample_addr_in,
  input  logic [7:0]  sample_len_in,
  input  logic        status_write,
  input  logic        enable,
  input  logic        dma_ack,
  input  logic [7:0]  dma_data,
  output logic        dma_req,
  output logic [15:0] dma_addr,
  output logic        bytes_remaining_non_zero,
  output logic        irq,
  output logic [6:0]  out
);

  logic [8:0]  timer;
  logic [8:0]  rate_m1;
  logic [15:0] cur_addr;
  logic [11:0] bytes_remaining;
  logic [7:0]  sample_buffer;
  logic        buffer_full;
  logic [7:0]  shift_reg;
  logic [3:0]  bits_remaining;
  logic        silence;

  logic        ack_accept;
  logic        out_clk;
  logic        buf_consume;
  logic        last_byte;
  logic [15:0] start_addr;
  logic [11:0] start_len;
  logic [15:0] next_addr;

  // Reload values are rate-1 so that the period is exactly `rate` CPU cycles.
  always_comb begin
    rate_m1 = 9'd427;
    case (rate_index)
      4'd0:  rate_m1 = 9'd427;
      4'd1:  rate_m1 = 9'd379;
      4'd2:  rate_m1 = 9'd339;
      4'd3:  rate_m1 = 9'd319;
      4'd4:  rate_m1 = 9'd285;
      4'd5:  rate_m1 = 9'd253;
      4'd6:  rate_m1 = 9'd225;
      4'd7:  rate_m1 = 9'd213;
      4'd8:  rate_m1 = 9'd189;
      4'd9:  rate_m1 = 9'd159;
      4'd10: rate_m1 = 9'd141;
      4'd11: rate_m1 = 9'd127;
      4'd12: rate_m1 = 9'd105;
      4'd13: rate_m1 = 9'd83;
      4'd14: rate_m1 = 9'd71;
      4'd15: rate_m1 = 9'd53;
      default: rate_m1 = 9'd427;
    endcase
  end

  assign dma_req                  = !buffer_full && (bytes_remaining != 12'd0);
  assign dma_addr                 = cur_addr;
  assign bytes_remaining_non_zero = (bytes_remaining != 12'd0);

  assign ack_accept  = dma_ack && dma_req;
  assign out_clk     = cpu_clk_en && (timer == 9'd0);
  // The shifter reloads from the buffer on the last bit of an output cycle.
  assign buf_consume = out_clk && (bits_remaining == 4'd1) && buffer_full;
  assign last_byte   = (bytes_remaining == 12'd1);
  assign start_addr  = {2'b11, sample_addr_in, 6'b000000};
  assign start_len   = {sample_len_in, 4'b0000} + 12'd1;
  // Sample fetches stay in $8000-$FFFF.
  assign next_addr   = (cur_addr == 16'hFFFF) ? 16'h8000 : cur_addr + 16'd1;

  // Rate timer; rate_index is only looked at on reload.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      timer <= 9'd427;
    end else if (cpu_clk_en) begin
      if (timer == 9'd0) timer <= rate_m1;
      else               timer <= timer - 9'd1;
    end
  end

  // Output unit: level, shifter, bit counter, silence flag.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      out            <= 7'd0;
      shift_reg      <= 8'd0;
      bits_remaining <= 4'd8;
      silence        <= 1'b1;
    end else begin
      // A direct load overrides a delta landing on the same edge.
      if (direct_load) begin
        out <= direct_load_data;
      end else if (out_clk && !silence) begin
        if (shift_reg[0]) begin
          if (out <= 7'd125) out <= out + 7'd2;
        end else if (out >= 7'd2) begin
          out <= out - 7'd2;
        end
      end
      if (out_clk) begin
        shift_reg      <= {1'b0, shift_reg[7:1]};
        bits_remaining <= bits_remaining - 4'd1;
        if (bits_remaining == 4'd1) begin
          bits_remaining <= 4'd8;
          if (buffer_full) begin
            shift_reg <= sample_buffer;
            silence   <= 1'b0;
          end else begin
            silence <= 1'b1;
          end
        end
      end
    end
  end

  // Memory reader: sample buffer, address and byte counter.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sample_buffer   <= 8'd0;
      buffer_full     <= 1'b0;
      cur_addr        <= 16'hC000;
      bytes_remaining <= 12'd0;
    end else begin
      // An ack only happens while the buffer is empty, so it never collides
      // with consumption; the shifter has already seen the empty buffer.
      if (ack_accept) begin
        sample_buffer <= dma_data;
        buffer_full   <= 1'b1;
      end else if (buf_consume) begin
        buffer_full <= 1'b0;
      end

      if (ack_accept) begin
        if (last_byte && loop) begin
          cur_addr        <= start_addr;
          bytes_remaining <= start_len;
        end else begin
          cur_addr        <= next_addr;
          bytes_remaining <= bytes_remaining - 12'd1;
        end
      end else if (status_write && enable && (bytes_remaining == 12'd0)) begin
        cur_addr        <= start_addr;
        bytes_remaining <= start_len;
      end

      // Disabling the channel clears the count even when a byte lands now.
      if (status_write && !enable) bytes_remaining <= 12'd0;
    end
  end

  // Interrupt flag: irq_en low holds it clear; a $4015 write clears it and
  // beats a set from an end-of-sample ack on the same edge.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      irq <= 1'b0;
    end else if (!irq_en || status_write) begin
      irq <= 1'b0;
    end else if (ack_accept && last_byte && !loop) begin
      irq <= 1'b1;
    end
  end

endmodule

// File: doc/dmc_channel.md
# dmc_channel

Delta-modulation (DMC) channel of the APU: it fetches 1-bit delta sample bytes from CPU address space through a DMA request/acknowledge handshake and produces the 7-bit `dmc` level for the non-linear mixer. It also raises the DMC interrupt and the bytes-remaining status bit used by $4015 reads. Register fields come from the APU memory-mapped register array ($4010–$4013, $4015 bit 4). The one-cycle write strobes come from the register update vector.

## Interface
No parameters. Rate table is NTSC, fixed.

- clk  in  1  system clock
- rst_l  in  1  asynchronous active-low reset
- cpu_clk_en  in  1  one-cycle pulse per CPU cycle; all channel state advances only on it, except handshake/register strobes
- irq_en  in  1  $4010[7]
- loop  in  1  $4010[6]
- rate_index  in  4  $4010[3:0]
- direct_load  in  1  write strobe for $4011
- direct_load_data  in  7  $4011[6:0]
- sample_addr_in  in  8  $4012
- sample_len_in  in  8  $4013
- status_write  in  1  write strobe for $4015
- enable  in  1  $4015[4], sampled on status_write
- dma_ack  in  1  one-cycle pulse, dma_data valid
- dma_data  in  8  fetched sample byte
- dma_req  out  1  fetch request
- dma_addr  out  16  fetch address
- bytes_remaining_non_zero  out  1  to status read bit 4
- irq  out  1  DMC interrupt flag, active high
- out  out  7  output level to mixer

## Operation
- Reset values:
  - out=0, irq=0, dma_req=0.
  - cur_addr=$C000, bytes_remaining=0, sample buffer empty.
  - shift=0, bits_remaining=8, silence=1.
  - timer=427.
- Rate table, in CPU cycles: 428,380,340,320,286,254,226,214,190,160,142,128,106,84,72,54.
- Timer:
  - Decrements on cpu_clk_en.
  - At 0 it reloads with rate-1 and clocks the output unit, so the period is exactly `rate` CPU cycles.
  - A change of rate_index takes effect at the next reload.
- Output unit clock:
  - If !silence:
    - shift[0]=1: out+=2 if out<=125.
    - shift[0]=0: out-=2 if out>=2.
    - Otherwise out is unchanged.
  - In all cases: shift>>=1, bits_remaining-=1.
  - When bits_remaining reaches 0, the same clock also does:
    - bits_remaining=8.
    - Buffer empty: silence=1.
    - Buffer full: shift=buffer, silence=0, buffer becomes empty.
- Direct load: out=direct_load_data. If coincident with an output delta, direct load wins.
- Memory reader:
  - dma_req = buffer_empty && bytes_remaining!=0, decoded from registers.
  - dma_addr = cur_addr.
  - dma_ack is ignored unless dma_req=1.
  - On accepted ack:
    - buffer=dma_data, buffer becomes full.
    - cur_addr+=1; $FFFF wraps to $8000.
    - bytes_remaining-=1.
  - If bytes_remaining becomes 0 on an accepted ack:
    - loop=1: cur_addr=$C000+sample_addr_in*64, bytes_remaining=sample_len_in*16+1.
    - Else if irq_en=1: irq=1.
- status_write:
  - irq=0 in all cases.
  - enable=0: bytes_remaining=0.
  - enable=1 and bytes_remaining==0: restart with cur_addr=start, bytes_remaining=len.
  - enable=1 and bytes_remaining!=0: no change.
- irq_en=0 forces irq=0, level-sensitive, every cycle.
- bytes_remaining_non_zero = (bytes_remaining!=0).
- Simultaneous events:
  - Ack and buffer consumption in the same cycle: the shifter takes the pre-ack buffer state (empty → silence). The ack data lands in the buffer.
  - Ack and status_write enable=0 in the same cycle: the byte is still buffered, and bytes_remaining ends at 0.
  - Ack and status_write: irq clear wins over an irq set in the same cycle.
  - Reset mid-fetch drops dma_req immediately (asynchronous). Any later ack is ignored.

## Timing
- Register effects (direct_load, status_write, ack) are visible the cycle after the strobe.
- dma_req rises the cycle after the buffer becomes empty with bytes remaining, including the cycle after an enabling status_write.
- dma_req falls the cycle after the accepted ack.
- Handshake: dma_req stays high, with stable dma_addr, until ack or until bytes_remaining is cleared. No timeout.
- First audible delta comes no earlier than the first output-cycle boundary after the buffer fills, at most 8×rate CPU cycles later.
- out changes at most once per rate CPU cycles, in steps of 2, bounded to [0,127].

## Test plan
- direct_load with data 0x40 → out=0x40 the next cycle. No dma_req.
- Single-byte playback:
  - Setup: rate_index=15, sample_addr_in=0, sample_len_in=0, out=0x40, status_write enable=1.
  - → dma_req=1, dma_addr=$C000.
  - Ack with data 0xFF → bytes_remaining_non_zero=0.
  - After the next output-cycle boundary, out steps 0x42…0x50, one step every 54 CPU cycles.
  - irq=1 if irq_en=1.
- Clamp:
  - out=126 (direct load), byte 0xFF → out stays 126.
  - out=1, byte 0x00 → out stays 1.
- Address wrap: sample_addr_in=0xFF, sample_len_in=4 (65 bytes), ack each request → dma_addr sequence $FFC0..$FFFF, then $8000.
- Loop:
  - loop=1, irq_en=1, sample_len_in=0.
  - After the ack, dma_req reasserts at $C000 once the buffer drains; irq stays 0.
  - status_write enable=0 → dma_req=0 next cycle, bytes_remaining_non_zero=0.
- IRQ clear:
  - With irq=1, status_write → irq=0 next cycle.
  - Set irq again, drop irq_en → irq=0 next cycle.
  - Ack coincident with status_write → irq=0.
